// File: rtl/bin2bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int           DIG_W     = 6;
  localparam int           MAX_VAL   = 999;
  localparam logic [5:0]   DIGIT_ERR = 6'd15;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD nibble of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter driving three 7-segment digit decoders.
// One conversion takes DATA_W shift cycles plus one finish cycle; out-of-range values show DIGIT_ERR.
module bin2bcd_seq #(
  parameter int         DATA_W    = 10,
  parameter int         MAX_VAL   = bin2bcd_pkg::MAX_VAL,
  parameter logic [5:0] DIGIT_ERR = bin2bcd_pkg::DIGIT_ERR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bin_in,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [5:0]        dig_ones,
  output logic [5:0]        dig_tens,
  output logic [5:0]        dig_hund
);

  import bin2bcd_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [5:0]        ones_q, ones_d;
  logic [5:0]        tens_q, tens_d;
  logic [5:0]        hund_q, hund_d;
  logic [11:0]       bcd_corr;

  bcd_add3 u_add3_ones (.nib_in(bcd_q[3:0]),  .nib_out(bcd_corr[3:0]));
  bcd_add3 u_add3_tens (.nib_in(bcd_q[7:4]),  .nib_out(bcd_corr[7:4]));
  bcd_add3 u_add3_hund (.nib_in(bcd_q[11:8]), .nib_out(bcd_corr[11:8]));

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    hund_d     = hund_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = bin_in;
          bcd_d      = '0;
          cnt_d      = CNT_W'(DATA_W);
          ovf_pend_d = ({{(32-DATA_W){1'b0}}, bin_in} > 32'(MAX_VAL));
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d      = {bcd_corr[10:0], bin_q[DATA_W-1]};
        bin_d      = {bin_q[DATA_W-2:0], 1'b0};
        cnt_d      = cnt_q - 1'b1;
        // A carry out of the hundreds nibble can only come from an out-of-range input.
        ovf_pend_d = ovf_pend_q | bcd_corr[11];
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        ovf_d   = ovf_pend_q;
        state_d = IDLE;
        if (ovf_pend_q) begin
          ones_d = DIGIT_ERR;
          tens_d = DIGIT_ERR;
          hund_d = DIGIT_ERR;
        end else begin
          ones_d = {{(DIG_W-4){1'b0}}, bcd_q[3:0]};
          tens_d = {{(DIG_W-4){1'b0}}, bcd_q[7:4]};
          hund_d = {{(DIG_W-4){1'b0}}, bcd_q[11:8]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ones_q     <= '0;
      tens_q     <= '0;
      hund_q     <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hund_q     <= hund_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign dig_ones = ones_q;
  assign dig_tens = tens_q;
  assign dig_hund = hund_q;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (iterative shift-add-3).
- Turns the vending machine's binary amount (balance, price or change) into three decimal digits.
- Each digit drives one leddisplay 7-segment decoder downstream, so digit ports are 6 bits wide to match that decoder's num input.
- Out-of-range values produce the error code, which the decoder renders as 'E'.

Parameters:
- DATA_W, 10, width of the binary input; legal range 4..10.
- MAX_VAL, 999, largest value shown as digits; anything above is an overflow.
- DIGIT_ERR, 6'd15, digit code driven on overflow; any value >9 displays 'E' downstream.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request conversion; sampled only in IDLE.
- bin_in  in  DATA_W  unsigned binary value; captured on the accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; digit outputs updated on the same edge.
- ovf  out  1  latched overflow flag of the last conversion.
- dig_ones  out  6  units digit, 0..9 or DIGIT_ERR.
- dig_tens  out  6  tens digit, 0..9 or DIGIT_ERR.
- dig_hund  out  6  hundreds digit, 0..9 or DIGIT_ERR.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, ovf=0; all digits 6'd0; shift register and counter cleared. Reset mid-conversion aborts it; the old result is not restored; outputs show 0.
- FSM states are IDLE, SHIFT and FINISH.
- IDLE, start=1 at edge k:
  - Latch bin_in into the binary shift register.
  - Clear the 12-bit BCD accumulator.
  - Load the counter with DATA_W; go to SHIFT; busy=1.
- SHIFT, each edge:
  - Every 4-bit BCD nibble >=5 gets +3 (combinational correction).
  - Shift {bcd, bin} left by 1 and decrement the counter.
  - When the counter reaches 1 and the shift completes, go to FINISH.
  - This is exactly DATA_W shift edges, k+1..k+DATA_W.
- FINISH, edge k+DATA_W+1:
  - Register the digits and set done=1 for one cycle.
  - busy=0; return to IDLE.
  - Latency: done is high in the cycle after edge k+DATA_W+1, i.e. DATA_W+1 clocks after start was sampled (11 clocks for DATA_W=10).
- Overflow is decided from the captured input, not the BCD result:
  - If the captured value > MAX_VAL: ovf=1 and all three digits = DIGIT_ERR.
  - Otherwise ovf=0 and digits are the BCD nibbles zero-extended to 6 bits.
- Digit outputs and ovf hold the last result until the next done. No change during busy.
- start while busy (SHIFT or FINISH) is ignored. It is not queued.
- start asserted in the same cycle done is high is accepted, because the FSM is already in IDLE; back-to-back conversions run every DATA_W+2 clocks.
- bin_in changing during busy has no effect.
- Leading zeros are displayed as 0; there is no blanking.
- Widths: BCD accumulator is 12 bits. Values 1000..1023 (DATA_W=10) overflow the 3-digit range; the ovf rule covers them.

Decomposition:
- Package bin2bcd_pkg holds:
  - the state encoding: IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2;
  - DIGIT_ERR;
  - MAX_VAL;
  - digit width constant DIG_W=6.
- One sub-module, bcd_add3: a 4-bit combinational nibble corrector (in>=5 ? in+3 : in). It is instantiated three times in the shift datapath.

Test Plan:
- Reset, then bin_in=10'd0 with start -> after 11 clocks done pulses once; digits 0/0/0; ovf=0; busy high for exactly 11 cycles.
- bin_in=10'd375, start -> dig_hund=3, dig_tens=7, dig_ones=5 at done; outputs unchanged through a following idle period of 20 cycles.
- bin_in=10'd999, then 10'd1000, then 10'd1023, each started on the done cycle of the previous conversion -> results are 9/9/9 with ovf=0, then 15/15/15 with ovf=1, then 15/15/15 with ovf=1. Conversions run back-to-back with 12-clock spacing.
- start with bin_in=10'd42; pulse start again and change bin_in to 10'd800 at cycles 3 and 5 while busy -> single done; digits 0/4/2; the second start is ignored.
- start with bin_in=10'd512; assert rst_n=0 asynchronously mid-SHIFT (between edges) -> outputs go to 0 immediately with busy=0 and done=0. After release, start with 10'd7 -> 0/0/7.
- Sweep bin_in 0..1023 against a reference model -> all digits and ovf match. done is never high for more than one cycle.
